// File: rtl/reciprocal_pwl_pipe.sv
// reciprocal_pwl_pipe: 3-stage pipelined piecewise-linear reciprocal, 1/x ~= out_mant * 2^-(DATA_W+out_exp)
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data = operand handshake (unsigned x);
//        out_valid/out_ready = result handshake; out_mant = Q0.DATA_W mantissa; out_exp = MSB index of x;
//        out_dbz = x was zero (out_mant all-ones, out_exp 0).
module reciprocal_pwl_pipe #(
    parameter int DATA_W = 16,
    parameter int ROUND  = 0,
    localparam int EXP_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_dbz
);
    // S2 working format: 2 integer bits + DATA_W+3 fractional bits
    localparam int RW = DATA_W + 5;
    localparam logic [RW-1:0] C0 = RW'(51) << (DATA_W - 2);
    localparam logic [RW-1:0] C1 = RW'(9) << DATA_W;
    logic              w_adv;
    logic [EXP_W-1:0]  w_e;
    logic [DATA_W-1:0] w_m;
    logic [RW-1:0]     w_mx;
    logic [RW-1:0]     w_r;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_q;
    logic              r1_v;
    logic              r1_z;
    logic [DATA_W-1:0] r1_m;
    logic [EXP_W-1:0]  r1_e;
    logic              r2_v;
    logic              r2_z;
    logic [RW-3:0]     r2_r;
    logic [EXP_W-1:0]  r2_e;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    always_comb begin
        w_e = '0;
        for (int i = 0; i < DATA_W; i++) if (in_data[i]) w_e = EXP_W'(i);
    end

    assign w_m  = in_data << (EXP_W'(DATA_W - 1) - w_e);
    // m widened so that the /16 shift still lands on whole bits
    assign w_mx = {1'b0, r1_m, 4'b0};
    assign w_r  = r1_m[DATA_W-2] ? C1 - (w_mx >> 2) - (w_mx >> 4)
                                 : C0 - (w_mx >> 1) - (w_mx >> 3);
    // r2_r keeps the top DATA_W+1 fractional bits: [DATA_W:1] result, [0] guard
    assign w_sum = {1'b0, r2_r[DATA_W:1]} + (DATA_W+1)'(ROUND != 0 && r2_r[0]);
    assign w_q   = (|r2_r[DATA_W+2:DATA_W+1] || w_sum[DATA_W]) ? '1 : w_sum[DATA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_v      <= 1'b0;
            r1_z      <= 1'b0;
            r1_m      <= '0;
            r1_e      <= '0;
            r2_v      <= 1'b0;
            r2_z      <= 1'b0;
            r2_r      <= '0;
            r2_e      <= '0;
            out_valid <= 1'b0;
            out_dbz   <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
        end else if (w_adv) begin
            r1_v      <= in_valid;
            r1_z      <= in_data == '0;
            r1_m      <= w_m;
            r1_e      <= w_e;
            r2_v      <= r1_v;
            r2_z      <= r1_z;
            r2_r      <= (RW-2)'(w_r >> 2);
            r2_e      <= r1_e;
            out_valid <= r2_v;
            out_dbz   <= r2_z;
            out_mant  <= r2_z ? '1 : w_q;
            out_exp   <= r2_z ? '0 : r2_e;
        end
    end
endmodule

// File: tb/tb_reciprocal_pwl_pipe.sv
// tb_reciprocal_pwl_pipe: table-driven and scoreboard bench for reciprocal_pwl_pipe (DATA_W=16, ROUND=0 and 1)
module tb_reciprocal_pwl_pipe;
    typedef struct {
        logic [15:0] x;
        logic [15:0] m0;
        logic [15:0] m1;
        logic [3:0]  e;
        logic        z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_ready0, in_ready1, ov0, ov1, z0, z1;
    logic [15:0] m0, m1;
    logic [3:0]  e0, e1;
    int          checks = 0;
    int          errors = 0;
    int          n_push = 0;
    int          n_pop = 0;
    vec_t        q[$];
    vec_t        cur;

    always #5 clk = ~clk;

    reciprocal_pwl_pipe #(.DATA_W(16), .ROUND(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_mant(m0), .out_exp(e0), .out_dbz(z0)
    );
    reciprocal_pwl_pipe #(.DATA_W(16), .ROUND(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_mant(m1), .out_exp(e1), .out_dbz(z1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Real-valued reference of the two-segment line and final quantisation
    function automatic vec_t model(input logic [15:0] x);
        vec_t v;
        int   e;
        real  m, r, sc, t, rr;
        v.x = x;
        if (x == 16'h0) begin
            v.m0 = 16'hFFFF;
            v.m1 = 16'hFFFF;
            v.e  = 4'd0;
            v.z  = 1'b1;
            return v;
        end
        e  = $clog2(int'(x) + 1) - 1;
        m  = real'(x) / real'(longint'(1) << e);
        r  = (m >= 1.5) ? 1.125 - m / 4.0 - m / 16.0 : 1.59375 - m / 2.0 - m / 8.0;
        sc = r * 524288.0;
        t  = $floor(sc / 8.0);
        rr = $floor(sc / 8.0 + 0.5);
        if (rr > 65535.0) rr = 65535.0;
        v.m0 = 16'(longint'(t));
        v.m1 = 16'(longint'(rr));
        v.e  = 4'(e);
        v.z  = 1'b0;
        return v;
    endfunction

    always @(posedge rst) begin
        n_push -= q.size();
        q.delete();
    end

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready0) begin
            q.push_back(cur);
            n_push++;
        end
    end

    always @(negedge clk) begin
        vec_t v;
        if (!rst && ov0 && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 32'(ov0), 32'd0);
            end else begin
                v = q.pop_front();
                n_pop++;
                check("mant_round0", 32'(m0), 32'(v.m0));
                check("mant_round1", 32'(m1), 32'(v.m1));
                check("exp", 32'(e0), 32'(v.e));
                check("dbz", 32'(z0), 32'(v.z));
                check("valid_round1", 32'(ov1), 32'd1);
            end
        end
    end

    task automatic send(input vec_t v);
        int k;
        k = 0;
        cur = v;
        in_data = v.x;
        in_valid = 1'b1;
        do begin
            @(posedge clk);
            k++;
        end while (!in_ready0 && k < 50);
        if (!in_ready0) check("accept_timeout", 32'(in_ready0), 32'd1);
        #1;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
        #1;
    endtask

    task automatic latency_check(input string name);
        int k;
        k = 1;
        while (!ov0 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, 32'(k), 32'd3);
    endtask

    initial begin
        vec_t        tbl[6];
        logic [15:0] hm;
        logic [3:0]  he;
        tbl[0] = '{16'h0001, 16'hF800, 16'hF800, 4'd0,  1'b0};
        tbl[1] = '{16'h0003, 16'hA800, 16'hA800, 4'd1,  1'b0};
        tbl[2] = '{16'h8000, 16'hF800, 16'hF800, 4'd15, 1'b0};
        tbl[3] = '{16'hFFFF, 16'h8000, 16'h8001, 4'd15, 1'b0};
        tbl[4] = '{16'h0000, 16'hFFFF, 16'hFFFF, 4'd0,  1'b1};
        tbl[5] = '{16'h0005, 16'hD000, 16'hD000, 4'd2,  1'b0};
        #2;
        check("rst_out_valid", 32'(ov0), 32'd0);
        check("rst_in_ready", 32'(in_ready0), 32'd1);
        check("rst_mant", 32'(m0), 32'd0);
        check("rst_exp", 32'(e0), 32'd0);
        check("rst_dbz", 32'(z0), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(tbl[0]);
        in_valid = 1'b0;
        latency_check("latency_first_after_reset");
        wait_drain();
        for (int i = 0; i < 6; i++) send(tbl[i]);
        in_valid = 1'b0;
        wait_drain();
        for (int i = 0; i < 24; i++) send(model(16'($urandom)));
        for (int i = 1; i < 9; i++) send(model(16'((1 << i) + i)));
        in_valid = 1'b0;
        wait_drain();
        fork
            begin
                for (int i = 0; i < 8; i++) send(model(16'(i * 977 + 3)));
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                #1;
                hm = m0;
                he = e0;
                for (int j = 0; j < 5; j++) begin
                    check("stall_in_ready", 32'(in_ready0), 32'd0);
                    check("stall_out_valid", 32'(ov0), 32'd1);
                    check("stall_mant_stable", 32'(m0), 32'(hm));
                    check("stall_exp_stable", 32'(e0), 32'(he));
                    @(posedge clk);
                    #2;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("stall_no_loss", 32'(n_pop), 32'(n_push));
        send(model(16'h0123));
        send(model(16'h4567));
        send(model(16'h89AB));
        in_valid = 1'b0;
        check("inflight_out_valid", 32'(ov0), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(ov0), 32'd0);
        check("async_rst_mant", 32'(m0), 32'd0);
        check("async_rst_in_ready", 32'(in_ready0), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("no_stale_after_rst", 32'(ov0), 32'd0);
        send(model(16'h1234));
        in_valid = 1'b0;
        latency_check("latency_after_midstream_rst");
        wait_drain();
        check("total_in_out", 32'(n_pop), 32'(n_push));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reciprocal_pwl_pipe.md
RECIPROCAL_PWL_PIPE -- requirements
Module: reciprocal_pwl_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning input/output data width (legal 8..32).
REQ-002 The block SHALL have parameter ROUND, default 0, meaning 0 = truncate, 1 = round-half-up at final quantisation.
REQ-003 The block SHALL have localparam EXP_W = clog2(DATA_W), meaning the exponent field width.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all registers are rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit, meaning reset, asynchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning in_data is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts in_data this cycle.
REQ-008 The block SHALL have port in_data, input, DATA_W bits, meaning the unsigned integer operand x.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning the out_* fields are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning downstream accepts the result.
REQ-011 The block SHALL have port out_mant, output, DATA_W bits, meaning the reciprocal mantissa, unsigned Q0.DATA_W.
REQ-012 The block SHALL have port out_exp, output, EXP_W bits, meaning the exponent e, where 1/x ~= out_mant * 2^-(DATA_W+e).
REQ-013 The block SHALL have port out_dbz, output, 1 bit, meaning in_data was zero.

Function
REQ-014 The block SHALL accept a transfer on either interface only on a clock edge where valid && ready are both high.
REQ-015 The block SHALL implement a 3-stage pipeline: S1 normalise, S2 piecewise-linear (PWL) evaluation, S3 quantise/output register; each stage holds its own valid bit.
REQ-016 The block SHALL use a global advance enable, adv = !out_valid || out_ready, and SHALL drive in_ready = adv.
REQ-017 When adv=0, all stage registers SHALL hold and out_* SHALL remain stable while out_valid=1.
REQ-018 Latency SHALL be 3 cycles from input accept to out_valid when no stall occurs; throughput SHALL be 1 result per cycle.
REQ-019 In S1, e SHALL be the index of the most significant set bit of x.
REQ-020 In S1, m SHALL be x shifted left by (DATA_W-1-e), interpreted as Q1.(DATA_W-1) in [1,2).
REQ-021 In S2, segment select SHALL be s = m[DATA_W-2] (s=1 means m >= 1.5).
REQ-022 For s=0, S2 SHALL compute r = 1.59375 - m/2 - m/8.
REQ-023 For s=1, S2 SHALL compute r = 1.125 - m/4 - m/16.
REQ-024 S2 arithmetic SHALL use shifts and subtractions only (no multiplier), with DATA_W+3 fractional bits so that all shifts are exact.
REQ-025 In S3, r SHALL be reduced to DATA_W fractional bits: ROUND=0 drops the 3 guard bits; ROUND=1 adds guard-bit MSB, saturating at all-ones.
REQ-026 For x=0, out_dbz SHALL be 1, out_mant SHALL be all-ones and out_exp SHALL be 0; otherwise out_dbz SHALL be 0.
REQ-027 A bubble (in_valid=0 while adv=1) SHALL propagate as valid=0 and SHALL NOT alter results already in flight.

Reset
REQ-028 Asserting rst SHALL immediately clear all stage valid bits, out_valid, out_mant, out_exp and out_dbz to 0, independent of clk.
REQ-029 In-flight data SHALL be discarded on reset, and in_ready SHALL read 1 while rst is held.
REQ-030 The first accept after reset deassertion SHALL produce out_valid exactly 3 cycles later.

Verification (DATA_W=16)
REQ-031 The bench SHALL check: x=1, ROUND=0 -> out_mant=0xF800, out_exp=0, out_dbz=0, valid 3 cycles after accept.
REQ-032 The bench SHALL check: x=3 -> s=1, out_mant=0xA800, out_exp=1; and x=0x8000 -> out_mant=0xF800, out_exp=15.
REQ-033 The bench SHALL check: x=0xFFFF -> out_exp=15, out_mant=0x8000 with ROUND=0 and 0x8001 with ROUND=1.
REQ-034 The bench SHALL check: x=0 -> out_dbz=1, out_mant=0xFFFF, out_exp=0.
REQ-035 The bench SHALL check: 8 back-to-back inputs with out_ready held 0 from cycle 4 for 5 cycles -> in_ready=0 during the stall, outputs stable, no loss or duplication, order preserved.
REQ-036 The bench SHALL check: rst pulsed mid-stream with 3 items in flight -> out_valid=0 immediately, and no stale result appears after reset release.
